// File: rtl/controle_turno_if.sv
// Fire-request and collision-checker bundle for controle_turno.
// master = the turn controller, slave = the environment (player input + checker).
interface controle_turno_if;
  logic       fire;
  logic [3:0] x;
  logic [3:0] y;
  logic       col_ready;
  logic       col_hit;
  logic       col_enable;
  logic [3:0] col_x;
  logic [3:0] col_y;
  logic       jogador;
  logic       busy;
  logic       repeat_shot;
  logic       timeout_err;
  logic       shot_done;
  logic       last_hit;
  logic [4:0] hits_p1;
  logic [4:0] hits_p2;
  logic       game_over;
  logic       winner;

  modport master (
    input  fire, x, y, col_ready, col_hit,
    output col_enable, col_x, col_y, jogador, busy, repeat_shot, timeout_err,
           shot_done, last_hit, hits_p1, hits_p2, game_over, winner
  );

  modport slave (
    output fire, x, y, col_ready, col_hit,
    input  col_enable, col_x, col_y, jogador, busy, repeat_shot, timeout_err,
           shot_done, last_hit, hits_p1, hits_p2, game_over, winner
  );
endinterface

// File: rtl/controle_turno.sv
// Shot/turn controller feeding the collision checker: repeat filter, hit tallies, turn and winner.
// Optional EXTRA_TURN_ON_HIT_EN: a hit keeps the same shooter for another turn.
module controle_turno #(
  parameter int unsigned TOTAL_HITS = 17,
  parameter int unsigned TIMEOUT    = 16
) (
  input logic                clk,
  input logic                rst_n,
  controle_turno_if.master   bus
);

  typedef enum logic [2:0] {StIdle, StCheck, StFire, StResult, StDone} state_e;

  state_e       state_q;
  logic [3:0]   col_x_q, col_y_q;
  logic         jogador_q;
  logic         repeat_shot_q, timeout_err_q, shot_done_q, last_hit_q;
  logic [4:0]   hits_p1_q, hits_p2_q;
  logic         game_over_q, winner_q;
  logic         hit_acc_q;
  logic [7:0]   cnt_q;
  logic [255:0] map_q [2];

  logic [7:0]   shot_idx;
  logic [4:0]   cur_tally, new_tally;

  assign shot_idx = {col_y_q, col_x_q};

  // Saturating tally of the current shooter after the pending shot
  always_comb begin
    cur_tally = jogador_q ? hits_p2_q : hits_p1_q;
    new_tally = cur_tally;
    if (hit_acc_q && (cur_tally != 5'd31)) new_tally = cur_tally + 5'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      col_x_q       <= '0;
      col_y_q       <= '0;
      jogador_q     <= 1'b0;
      repeat_shot_q <= 1'b0;
      timeout_err_q <= 1'b0;
      shot_done_q   <= 1'b0;
      last_hit_q    <= 1'b0;
      hits_p1_q     <= '0;
      hits_p2_q     <= '0;
      game_over_q   <= 1'b0;
      winner_q      <= 1'b0;
      hit_acc_q     <= 1'b0;
      cnt_q         <= '0;
      map_q[0]      <= '0;
      map_q[1]      <= '0;
    end else begin
      repeat_shot_q <= 1'b0;
      timeout_err_q <= 1'b0;
      shot_done_q   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.fire) begin
            col_x_q <= bus.x;
            col_y_q <= bus.y;
            state_q <= StCheck;
          end
        end
        StCheck: begin
          if (map_q[jogador_q][shot_idx]) begin
            repeat_shot_q <= 1'b1;
            state_q       <= StIdle;
          end else begin
            hit_acc_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= StFire;
          end
        end
        StFire: begin
          hit_acc_q <= hit_acc_q | bus.col_hit;
          cnt_q     <= cnt_q + 8'd1;
          // A ready on the last allowed cycle still wins over the timeout
          if (bus.col_ready) begin
            state_q <= StResult;
          end else if (cnt_q == 8'(TIMEOUT - 1)) begin
            timeout_err_q <= 1'b1;
            state_q       <= StIdle;
          end
        end
        StResult: begin
          map_q[jogador_q][shot_idx] <= 1'b1;
          last_hit_q  <= hit_acc_q;
          shot_done_q <= 1'b1;
          if (jogador_q) hits_p2_q <= new_tally;
          else           hits_p1_q <= new_tally;
          if (new_tally == 5'(TOTAL_HITS)) begin
            game_over_q <= 1'b1;
            winner_q    <= jogador_q;
            state_q     <= StDone;
          end else begin
`ifdef EXTRA_TURN_ON_HIT_EN
            if (!hit_acc_q) jogador_q <= ~jogador_q;
`else
            jogador_q <= ~jogador_q;
`endif
            state_q <= StIdle;
          end
        end
        StDone:  state_q <= StDone;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Decoded straight from the state register so an async reset drops it at once
  assign bus.col_enable  = (state_q == StFire);
  assign bus.busy        = (state_q != StIdle);
  assign bus.col_x       = col_x_q;
  assign bus.col_y       = col_y_q;
  assign bus.jogador     = jogador_q;
  assign bus.repeat_shot = repeat_shot_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.shot_done   = shot_done_q;
  assign bus.last_hit    = last_hit_q;
  assign bus.hits_p1     = hits_p1_q;
  assign bus.hits_p2     = hits_p2_q;
  assign bus.game_over   = game_over_q;
  assign bus.winner      = winner_q;

endmodule

// File: tb/tb_controle_turno.sv
// Directed table-driven bench for controle_turno (TOTAL_HITS=2, TIMEOUT=16).
module tb_controle_turno;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  controle_turno_if bus ();

  controle_turno #(
    .TOTAL_HITS(2),
    .TIMEOUT   (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    int rdy;   // FIRE cycle (1-based) on which col_ready is raised, 0 = never
    int hit;   // FIRE cycle on which col_hit is raised, 0 = never
    int en;    // expected number of col_enable cycles
    int rep;
    int to;
    int done;
    int last;
    int p1;
    int p2;
    int jog;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one fire and play the checker until a result pulse or a 40-cycle bound
  task automatic do_shot(input logic [3:0] sx, input logic [3:0] sy, input int rdy, input int hit,
                         output int en, output int rep, output int to, output int done,
                         output int cx, output int cy);
    en = 0; rep = 0; to = 0; done = 0; cx = -1; cy = -1;
    @(negedge clk);
    bus.fire = 1'b1;
    bus.x    = sx;
    bus.y    = sy;
    @(negedge clk);
    bus.fire = 1'b0;
    for (int c = 0; c < 40 && !(rep != 0 || to != 0 || done != 0); c++) begin
      if (bus.repeat_shot) rep = 1;
      if (bus.timeout_err) to = 1;
      if (bus.shot_done)   done = 1;
      if (bus.col_enable) begin
        en++;
        if (en == 1) begin
          cx = int'(bus.col_x);
          cy = int'(bus.col_y);
        end
        bus.col_ready = (en == rdy);
        bus.col_hit   = (en == hit);
      end else begin
        bus.col_ready = 1'b0;
        bus.col_hit   = 1'b0;
      end
      if (!(rep != 0 || to != 0 || done != 0)) @(negedge clk);
    end
    bus.col_ready = 1'b0;
    bus.col_hit   = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int en, rep, to, done, cx, cy, w;
`ifdef EXTRA_TURN_ON_HIT_EN
    tbl[0] = '{4'd3, 4'd5, 4, 2,  4, 0, 0, 1, 1, 1, 0, 0};
    tbl[1] = '{4'd2, 4'd2, 2, 0,  2, 0, 0, 1, 0, 1, 0, 1};
    tbl[2] = '{4'd3, 4'd5, 1, 0,  1, 0, 0, 1, 0, 1, 0, 0};
    tbl[3] = '{4'd2, 4'd2, 1, 0,  0, 1, 0, 0, 0, 1, 0, 0};
    tbl[4] = '{4'd9, 4'd1, 0, 0, 16, 0, 1, 0, 0, 1, 0, 0};
    tbl[5] = '{4'd9, 4'd1, 3, 0,  3, 0, 0, 1, 0, 1, 0, 1};
    tbl[6] = '{4'd0, 4'd0, 1, 1,  1, 0, 0, 1, 1, 1, 1, 1};
    tbl[7] = '{4'd7, 4'd7, 1, 0,  1, 0, 0, 1, 0, 1, 1, 0};
`else
    tbl[0] = '{4'd3, 4'd5, 4, 2,  4, 0, 0, 1, 1, 1, 0, 1};
    tbl[1] = '{4'd3, 4'd5, 1, 0,  1, 0, 0, 1, 0, 1, 0, 0};
    tbl[2] = '{4'd2, 4'd2, 2, 0,  2, 0, 0, 1, 0, 1, 0, 1};
    tbl[3] = '{4'd7, 4'd7, 1, 0,  1, 0, 0, 1, 0, 1, 0, 0};
    tbl[4] = '{4'd2, 4'd2, 1, 0,  0, 1, 0, 0, 0, 1, 0, 0};
    tbl[5] = '{4'd9, 4'd1, 0, 0, 16, 0, 1, 0, 0, 1, 0, 0};
    tbl[6] = '{4'd9, 4'd1, 3, 0,  3, 0, 0, 1, 0, 1, 0, 1};
    tbl[7] = '{4'd0, 4'd0, 1, 1,  1, 0, 0, 1, 1, 1, 1, 0};
`endif
    bus.fire = 1'b0; bus.x = '0; bus.y = '0; bus.col_ready = 1'b0; bus.col_hit = 1'b0;

    // Reset state
    #12;
    chk("rst col_enable", int'(bus.col_enable), 0);
    chk("rst busy",       int'(bus.busy),       0);
    chk("rst jogador",    int'(bus.jogador),    0);
    chk("rst hits_p1",    int'(bus.hits_p1),    0);
    chk("rst hits_p2",    int'(bus.hits_p2),    0);
    chk("rst game_over",  int'(bus.game_over),  0);
    chk("rst pulses",     int'({bus.repeat_shot, bus.timeout_err, bus.shot_done}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_shot(tbl[i].x, tbl[i].y, tbl[i].rdy, tbl[i].hit, en, rep, to, done, cx, cy);
      chk($sformatf("v%0d en_cycles", i),   en,   tbl[i].en);
      chk($sformatf("v%0d repeat_shot", i), rep,  tbl[i].rep);
      chk($sformatf("v%0d timeout_err", i), to,   tbl[i].to);
      chk($sformatf("v%0d shot_done", i),   done, tbl[i].done);
      if (tbl[i].done != 0) chk($sformatf("v%0d last_hit", i), int'(bus.last_hit), tbl[i].last);
      if (tbl[i].en != 0) begin
        chk($sformatf("v%0d col_x", i), cx, int'(tbl[i].x));
        chk($sformatf("v%0d col_y", i), cy, int'(tbl[i].y));
      end
      chk($sformatf("v%0d hits_p1", i), int'(bus.hits_p1), tbl[i].p1);
      chk($sformatf("v%0d hits_p2", i), int'(bus.hits_p2), tbl[i].p2);
      chk($sformatf("v%0d jogador", i), int'(bus.jogador), tbl[i].jog);
      chk($sformatf("v%0d busy", i),    int'(bus.busy),    0);
    end

    // Player 1 reaches TOTAL_HITS=2; game freezes in DONE
    pulse_reset();
    do_shot(4'd1, 4'd1, 1, 1, en, rep, to, done, cx, cy);
    chk("go first hit p1", int'(bus.hits_p1), 1);
`ifndef EXTRA_TURN_ON_HIT_EN
    do_shot(4'd2, 4'd2, 1, 0, en, rep, to, done, cx, cy);
    chk("go p2 miss jogador", int'(bus.jogador), 0);
`endif
    do_shot(4'd3, 4'd3, 1, 1, en, rep, to, done, cx, cy);
    chk("go shot_done", done, 1);
    chk("go hits_p1",   int'(bus.hits_p1),   2);
    chk("go game_over", int'(bus.game_over), 1);
    chk("go winner",    int'(bus.winner),    0);
    chk("go jogador",   int'(bus.jogador),   0);
    chk("go busy",      int'(bus.busy),      1);
    do_shot(4'd4, 4'd4, 1, 1, en, rep, to, done, cx, cy);
    chk("go ignored en",   en,   0);
    chk("go ignored done", done, 0);
    chk("go still over",   int'(bus.game_over), 1);
    chk("go still busy",   int'(bus.busy),      1);

    // Asynchronous reset in the middle of FIRE
    pulse_reset();
    do_shot(4'd1, 4'd1, 1, 1, en, rep, to, done, cx, cy);
    chk("mid pre hits_p1", int'(bus.hits_p1), 1);
    @(negedge clk);
    bus.fire = 1'b1; bus.x = 4'd6; bus.y = 4'd6;
    @(negedge clk);
    bus.fire = 1'b0;
    w = 0;
    while (!bus.col_enable && w < 5) begin
      @(negedge clk);
      w++;
    end
    chk("mid reached FIRE", int'(bus.col_enable), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid col_enable", int'(bus.col_enable), 0);
    chk("mid busy",       int'(bus.busy),       0);
    chk("mid hits_p1",    int'(bus.hits_p1),    0);
    chk("mid jogador",    int'(bus.jogador),    0);
    @(negedge clk);
    rst_n = 1'b1;
    do_shot(4'd1, 4'd1, 1, 0, en, rep, to, done, cx, cy);
    chk("mid map cleared rep", rep,  0);
    chk("mid map cleared done", done, 1);
    chk("mid after jogador", int'(bus.jogador), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
